seg_display_scheduler: RTL and testbench
========================================

Name: seg_display_scheduler

Overview:
- Round-robin scheduler that shares one 8-bit seven-segment display output among N_REQ requesters. Typical requesters: sequence-detector status, digit counters, and test-pattern sources.
- Each granted requester's 4-bit digit code (plus decimal point) is latched, decoded and held on the display for HOLD_CYCLES cycles.
- A blank gap separates consecutive owners.
- The block sits between the requester logic and the top-level uo_out pins.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- HOLD_CYCLES, 1000, cycles a granted digit stays on the display (>=1).
- GAP_CYCLES, 2, blank cycles after each owner releases (0 = no gap).
- OWN_W, 2, owner index width; must equal clog2(N_REQ).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N_REQ  per-requester request level.
- digit  input  4*N_REQ  digit code; requester i uses bits [4i+3:4i].
- dp  input  N_REQ  per-requester decimal-point flag.
- grant  output  N_REQ  one-hot; high while requester owns the display.
- done  output  N_REQ  one-cycle pulse marking normal completion of a hold.
- busy  output  1  high in SHOW or GAP.
- owner  output  OWN_W  index of current or last owner.
- seg_out  output  8  display pattern {dp,g,f,e,d,c,b,a}, 1 = segment lit.

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - state=IDLE; grant=0, done=0, busy=0, owner=0, seg_out=8'h00.
  - Round-robin pointer ptr=0; hold/gap counter=0.
  - Reset mid-SHOW or mid-GAP aborts immediately; no done pulse is issued.
- Decode of the latched code (dp latched alongside drives bit7):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10..15 show dash 40.
- State IDLE:
  - seg_out=00.
  - If any req: select the first requester with req=1 searching from ptr upward with wrap (ptr, ptr+1, ..., N_REQ-1, 0, ...).
  - Latch its digit and dp, set owner, set its grant bit, load counter=HOLD_CYCLES-1, go to SHOW.
  - All outputs are registered: req sampled high at edge t gives grant and seg_out valid after edge t.
- State SHOW:
  - seg_out=decode(latched digit, latched dp).
  - Latched values are used; changes on the digit and dp inputs during SHOW are ignored.
  - Counter decrements each cycle; grant is high for exactly HOLD_CYCLES cycles.
  - Normal end: in the cycle where counter==0, done[owner] is asserted for that single cycle, coincident with the last grant cycle.
  - On normal end: ptr=owner+1 (wrap to 0 past N_REQ-1); next state GAP if GAP_CYCLES>0, else IDLE.
  - Abort: if req[owner] is sampled low during SHOW, grant drops on the next edge and no done is issued. ptr advances as for a normal end; go to GAP/IDLE.
- State GAP:
  - seg_out=00, grant=0, busy=1.
  - Lasts exactly GAP_CYCLES cycles, then IDLE.
  - Requests arriving during GAP wait; they are arbitrated in IDLE.
- Ordering and priority:
  - A requester that keeps req high after done is re-eligible, but it is searched last because ptr has advanced past it.
  - Simultaneous requests are resolved purely by ptr order; no starvation.
  - Worst-case wait is (N_REQ-1)*(HOLD_CYCLES+GAP_CYCLES+1) cycles.
- busy=1 in SHOW and GAP, 0 in IDLE.
- owner holds its last value in IDLE and GAP.
- Only one grant bit is ever high; done is never high outside SHOW.

Test Plan (HOLD_CYCLES=4, GAP_CYCLES=1, N_REQ=4):
- Reset then idle: rst=1 for 2 cycles, req=0 -> grant=0, done=0, busy=0, owner=0, seg_out=00 every cycle.
- Single request: req=0001, digit0=3, dp0=1 -> grant=0001 for 4 cycles with seg_out=CF. done[0] pulses on the 4th grant cycle. Then 1 cycle of seg_out=00 with busy=1. Then IDLE; if req0 is still high, grant=0001 again.
- Round robin: req=1111 constant, digits 1,2,3,4 -> owners sequence 0,1,2,3,0.
  - seg_out sequence 06,5B,4F,66, each for 4 cycles, with a 00 cycle between.
  - Exactly one done pulse per hold.
- Abort: req=0100, digit2=9; drop req2 after 2 grant cycles -> grant=0 on the next edge, done stays 0. GAP of 1 cycle, then IDLE; ptr=3.
  - A subsequent req=0101 grants requester 0 first (search 3,0).
- Mid-hold changes and invalid code: digit0 changes 5->7 during SHOW -> seg_out stays 6D for all 4 cycles. Separately, code 12 -> seg_out=40.
- Reset mid-SHOW: rst=1 on the 2nd grant cycle -> next cycle grant=0, busy=0, seg_out=00, no done pulse, ptr=0.

Source files
------------

// File: rtl/seg_display_scheduler.sv
// Round-robin owner of a single seven-segment display: each granted requester's
// digit is latched, decoded and held for HOLD_CYCLES, followed by a blank gap.
module seg_display_scheduler #(
  parameter int N_REQ       = 4,
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 2,
  parameter int OWN_W       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   digit,
  input  logic [N_REQ-1:0]     dp,
  output logic [N_REQ-1:0]     grant,
  output logic [N_REQ-1:0]     done,
  output logic                 busy,
  output logic [OWN_W-1:0]     owner,
  output logic [7:0]           seg_out
);

  localparam int MAXC  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [OWN_W-1:0]  ptr_q;
  logic [OWN_W-1:0]  owner_q;
  logic [N_REQ-1:0]  grant_q;
  logic [N_REQ-1:0]  done_q;
  logic              busy_q;
  logic [7:0]        seg_q;

  logic              found_d;
  logic [OWN_W-1:0]  pick_d;
  logic [OWN_W-1:0]  ptr_next_d;
  int                idx;

  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'd0:    decode = 7'h3F;
      4'd1:    decode = 7'h06;
      4'd2:    decode = 7'h5B;
      4'd3:    decode = 7'h4F;
      4'd4:    decode = 7'h66;
      4'd5:    decode = 7'h6D;
      4'd6:    decode = 7'h7D;
      4'd7:    decode = 7'h07;
      4'd8:    decode = 7'h7F;
      4'd9:    decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  // First requester at or after ptr, wrapping around.
  always_comb begin
    found_d = 1'b0;
    pick_d  = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr_q) + k) % N_REQ;
      if (!found_d && req[idx]) begin
        found_d = 1'b1;
        pick_d  = OWN_W'(idx);
      end
    end
  end

  assign ptr_next_d = (owner_q == OWN_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      seg_q   <= 8'h00;
    end else begin
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (found_d) begin
            state_q <= SHOW;
            owner_q <= pick_d;
            grant_q <= N_REQ'(1) << pick_d;
            done_q  <= (HOLD_CYCLES == 1) ? (N_REQ'(1) << pick_d) : '0;
            busy_q  <= 1'b1;
            seg_q   <= {dp[pick_d], decode(digit[pick_d*4 +: 4])};
            cnt_q   <= CNT_W'(HOLD_CYCLES - 1);
          end
        end

        SHOW: begin
          // The final hold cycle has already shown done, so it always ends normally.
          if (cnt_q == '0 || !req[owner_q]) begin
            ptr_q   <= ptr_next_d;
            grant_q <= '0;
            seg_q   <= 8'h00;
            if (GAP_CYCLES > 0) begin
              state_q <= GAP;
              cnt_q   <= CNT_W'(GAP_CYCLES - 1);
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              cnt_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
              done_q <= grant_q;
            end
          end
        end

        GAP: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          seg_q   <= 8'h00;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign done    = done_q;
  assign busy    = busy_q;
  assign owner   = owner_q;
  assign seg_out = seg_q;

endmodule

// File: tb/tb_seg_display_scheduler.sv
// Directed bench for seg_display_scheduler with HOLD=4, GAP=1, four requesters.
module tb_seg_display_scheduler;

  localparam int N = 4;
  localparam int H = 4;
  localparam int G = 1;
  localparam int W = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [4*N-1:0] digit;
  logic [N-1:0] dp;
  logic [N-1:0] grant;
  logic [N-1:0] done;
  logic         busy;
  logic [W-1:0] owner;
  logic [7:0]   seg_out;

  int total = 0;
  int bad   = 0;

  logic [18:0] obs;
  logic [18:0] exp;

  seg_display_scheduler #(
    .N_REQ(N), .HOLD_CYCLES(H), .GAP_CYCLES(G), .OWN_W(W)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .digit(digit), .dp(dp),
    .grant(grant), .done(done), .busy(busy), .owner(owner), .seg_out(seg_out)
  );

  always #5 clk = ~clk;

  assign obs = {grant, done, busy, owner, seg_out};

  // Outputs are examined 1 time unit after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    req = '0; digit = '0; dp = '0;
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      exp = 19'h0;
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL reset_c%0d got=%h want=%h", c, obs, exp);
      end
    end
    rst = 1'b0;
    tick();
    exp = 19'h0;
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL reset_idle got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_single;
    req = 4'b0001; digit = 16'h0003; dp = 4'b0001;
    for (int h = 0; h < H; h++) begin
      tick();
      exp = {4'b0001, (h == H-1) ? 4'b0001 : 4'b0000, 1'b1, 2'd0, 8'hCF};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL single_hold%0d got=%h want=%h", h, obs, exp);
      end
    end
    tick();
    exp = {4'b0, 4'b0, 1'b1, 2'd0, 8'h00};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL single_gap got=%h want=%h", obs, exp);
    end
    tick();
    exp = {4'b0, 4'b0, 1'b0, 2'd0, 8'h00};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL single_idle got=%h want=%h", obs, exp);
    end
    tick();
    exp = {4'b0001, 4'b0, 1'b1, 2'd0, 8'hCF};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL single_regrant got=%h want=%h", obs, exp);
    end
    req = '0;
    tick();
    tick();
  endtask

  task automatic test_round_robin;
    logic [7:0] segs [4];
    logic [N-1:0] oh;
    int own;
    int dones;
    segs[0] = 8'h06; segs[1] = 8'h5B; segs[2] = 8'h4F; segs[3] = 8'h66;
    dones = 0;
    req = '0;
    do_reset();
    req = 4'b1111; digit = 16'h4321; dp = 4'b0000;
    for (int n = 0; n < 5; n++) begin
      own = n % N;
      oh  = 4'b0001 << own;
      for (int h = 0; h < H; h++) begin
        tick();
        if (done != 4'b0) dones++;
        exp = {oh, (h == H-1) ? oh : 4'b0000, 1'b1, 2'(own), segs[own]};
        total++;
        if (obs !== exp) begin
          bad++;
          $display("[TB] FAIL rr_owner%0d_hold%0d got=%h want=%h", n, h, obs, exp);
        end
      end
      tick();
      if (done != 4'b0) dones++;
      exp = {4'b0, 4'b0, 1'b1, 2'(own), 8'h00};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL rr_gap%0d got=%h want=%h", n, obs, exp);
      end
      tick();
      exp = {4'b0, 4'b0, 1'b0, 2'(own), 8'h00};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL rr_idle%0d got=%h want=%h", n, obs, exp);
      end
    end
    total++;
    if (dones !== 5) begin
      bad++;
      $display("[TB] FAIL rr_done_count got=%0d want=5", dones);
    end
  endtask

  task automatic test_abort;
    req = '0;
    do_reset();
    req = 4'b0100; digit = 16'h0900; dp = '0;
    for (int h = 0; h < 2; h++) begin
      tick();
      exp = {4'b0100, 4'b0, 1'b1, 2'd2, 8'h6F};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL abort_hold%0d got=%h want=%h", h, obs, exp);
      end
    end
    req = '0;
    tick();
    exp = {4'b0, 4'b0, 1'b1, 2'd2, 8'h00};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL abort_drop got=%h want=%h", obs, exp);
    end
    tick();
    exp = {4'b0, 4'b0, 1'b0, 2'd2, 8'h00};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL abort_idle got=%h want=%h", obs, exp);
    end
    req = 4'b0101;
    tick();
    exp = {4'b0001, 4'b0, 1'b1, 2'd0, 8'h3F};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL abort_ptr_wrap got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_midhold;
    req = '0;
    do_reset();
    req = 4'b0001; digit = 16'h0005; dp = '0;
    tick();
    digit = 16'h0007;
    for (int h = 0; h < H; h++) begin
      if (h > 0) tick();
      exp = {4'b0001, (h == H-1) ? 4'b0001 : 4'b0000, 1'b1, 2'd0, 8'h6D};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("[TB] FAIL midhold_h%0d got=%h want=%h", h, obs, exp);
      end
    end
    digit = 16'h000C;
    tick();
    tick();
    tick();
    exp = {4'b0001, 4'b0, 1'b1, 2'd0, 8'h40};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL invalid_code got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_reset_mid;
    req = '0;
    do_reset();
    digit = 16'h0000; dp = '0;
    req = 4'b0010;
    tick();
    req = '0;
    tick();
    tick();
    req = 4'b0100;
    tick();
    tick();
    exp = {4'b0100, 4'b0, 1'b1, 2'd2, 8'h3F};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL rstmid_pre got=%h want=%h", obs, exp);
    end
    rst = 1'b1;
    tick();
    exp = 19'h0;
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL rstmid_abort got=%h want=%h", obs, exp);
    end
    rst = 1'b0;
    req = 4'b0110;
    tick();
    exp = {4'b0010, 4'b0, 1'b1, 2'd1, 8'h3F};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL rstmid_ptr got=%h want=%h", obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; req = '0; digit = '0; dp = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_abort();
    test_midhold();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
